// File: rtl/char_buf_port_arbiter_pkg.sv
// Shared constants and types for the character-buffer host-port arbiter.
//   ADDR_W/DATA_W/BE_W : SRAM geometry (2048 x 32, four byte lanes)
//   req_idx_e          : requester index, also the round-robin order
//   fill_state_e       : fill engine state, exported for debug visibility
package char_buf_port_arbiter_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        REQ_M0   = 2'd0,
        REQ_M1   = 2'd1,
        REQ_FILL = 2'd2
    } req_idx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // Round-robin successor: m0 -> m1 -> fill -> m0.
    function automatic req_idx_e next_req(input req_idx_e cur);
        case (cur)
            REQ_M0:  next_req = REQ_M1;
            REQ_M1:  next_req = REQ_FILL;
            default: next_req = REQ_M0;
        endcase
    endfunction

endpackage

// File: rtl/char_buf_port_arbiter_if.sv
// Avalon-MM pipelined-read master bundle for one requester of the arbiter.
//   master modport : drives address/read/write/byteenable/writedata
//   slave modport  : drives waitrequest/readdata/readdatavalid
// Handshake: a request (read or write high) is accepted in exactly the
// cycle where waitrequest is low; the master must hold its request and
// qualifiers stable while waitrequest is high. An accepted read returns
// with readdatavalid high exactly one cycle later; readdata is only
// meaningful while readdatavalid is high.
interface char_buf_port_arbiter_if;
    import char_buf_port_arbiter_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/char_buf_fill_engine.sv
// Screen clear/fill engine: writes one latched word over a run of
// consecutive addresses (wrapping at 2048) whenever the arbiter grants it.
//   i_start/i_base/i_count/i_data : start pulse and fill job parameters
//   i_abort                       : stop an active fill, no done pulse
//   i_gnt                         : arbiter accepted this cycle's fill write
//   o_req/o_addr/o_data           : write request towards the arbiter
//   o_busy/o_done                 : status; o_done is a one-cycle pulse
//   o_state                       : current state for debug
module char_buf_fill_engine
    import char_buf_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_abort,
    input  logic              i_gnt,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output fill_state_e       o_state
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_FILL = FILL;
    localparam logic [1:0] S_DONE = DONE;
    localparam logic [ADDR_W:0] REM_LAST = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_count != '0) begin
                            r_state <= S_FILL;
                            r_addr  <= i_base;
                            r_rem   <= i_count;
                            r_data  <= i_data;
                        end else begin
                            // Empty job: report completion without touching RAM.
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FILL: begin
                    // A write granted in the abort cycle has already reached
                    // the RAM; the counters just stop mattering afterwards.
                    if (i_gnt) begin
                        r_addr <= r_addr + 1'b1;
                        r_rem  <= r_rem - 1'b1;
                    end
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (i_gnt && r_rem == REM_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req   = (r_state == S_FILL);
    assign o_busy  = (r_state == S_FILL);
    assign o_done  = (r_state == S_DONE);
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_state = fill_state_e'(r_state);

endmodule

// File: rtl/char_buf_port_arbiter.sv
// Round-robin arbiter for the host port (s1) of the 2048x32 character
// buffer SRAM. Requesters: m0 (processor bridge), m1 (DMA), fill engine.
//   clk, reset_n        : clock, asynchronous active-low reset
//   m0, m1              : Avalon-MM slave-side bundles
//   fill_*              : fill job control and status
//   ram_*               : SRAM s1 port (1-cycle read latency, clken tied high)
//   fill_state_dbg      : fill engine state for debug
module char_buf_port_arbiter
    import char_buf_port_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    char_buf_port_arbiter_if.slave  m0,
    char_buf_port_arbiter_if.slave  m1,
    input  logic                    fill_start,
    input  logic [ADDR_W-1:0]       fill_base,
    input  logic [ADDR_W:0]         fill_count,
    input  logic [DATA_W-1:0]       fill_data,
    input  logic                    fill_abort,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic [ADDR_W-1:0]       ram_address,
    output logic                    ram_chipselect,
    output logic                    ram_write,
    output logic [BE_W-1:0]         ram_byteenable,
    output logic [DATA_W-1:0]       ram_writedata,
    input  logic [DATA_W-1:0]       ram_readdata,
    output fill_state_e             fill_state_dbg
);

    logic              w_fill_req;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_data;
    logic [2:0]        w_req;
    logic              w_gnt_valid;
    req_idx_e          w_gnt_idx;
    logic              w_gnt_m0;
    logic              w_gnt_m1;
    logic              w_gnt_fill;
    req_idx_e          r_last;
    logic              r_rd_valid;
    req_idx_e          r_rd_owner;

    char_buf_fill_engine u_fill (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (fill_start),
        .i_base  (fill_base),
        .i_count (fill_count),
        .i_data  (fill_data),
        .i_abort (fill_abort),
        .i_gnt   (w_gnt_fill),
        .o_req   (w_fill_req),
        .o_addr  (w_fill_addr),
        .o_data  (w_fill_data),
        .o_busy  (fill_busy),
        .o_done  (fill_done),
        .o_state (fill_state_dbg)
    );

    assign w_req = {w_fill_req, m1.read | m1.write, m0.read | m0.write};

    // Search starts just after the last winner. Grants are suppressed while
    // reset is asserted so every master sees waitrequest high immediately.
    always_comb begin
        req_idx_e v_cand;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = REQ_M0;
        v_cand      = r_last;
        for (int k = 0; k < 3; k++) begin
            v_cand = next_req(v_cand);
            if (!w_gnt_valid && w_req[v_cand] && reset_n) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = v_cand;
            end
        end
    end

    assign w_gnt_m0   = w_gnt_valid && (w_gnt_idx == REQ_M0);
    assign w_gnt_m1   = w_gnt_valid && (w_gnt_idx == REQ_M1);
    assign w_gnt_fill = w_gnt_valid && (w_gnt_idx == REQ_FILL);

    // read & write together is a write: ram_write follows the write strobe.
    always_comb begin
        ram_chipselect = w_gnt_valid;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (w_gnt_m0) begin
            ram_write      = m0.write;
            ram_address    = m0.address;
            ram_byteenable = m0.byteenable;
            ram_writedata  = m0.writedata;
        end else if (w_gnt_m1) begin
            ram_write      = m1.write;
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
        end else if (w_gnt_fill) begin
            ram_write      = 1'b1;
            ram_address    = w_fill_addr;
            ram_byteenable = '1;
            ram_writedata  = w_fill_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last     <= REQ_FILL;
            r_rd_valid <= 1'b0;
            r_rd_owner <= REQ_M0;
        end else begin
            r_rd_valid <= (w_gnt_m0 && m0.read && !m0.write) ||
                          (w_gnt_m1 && m1.read && !m1.write);
            r_rd_owner <= w_gnt_idx;
            if (w_gnt_valid) begin
                r_last <= w_gnt_idx;
            end
        end
    end

    assign m0.waitrequest   = !w_gnt_m0;
    assign m1.waitrequest   = !w_gnt_m1;
    assign m0.readdatavalid = r_rd_valid && (r_rd_owner == REQ_M0);
    assign m1.readdatavalid = r_rd_valid && (r_rd_owner == REQ_M1);
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;

endmodule

// File: doc/char_buf_port_arbiter.md
Name: char_buf_port_arbiter

Overview:
- Shares the host-side port (s1) of the 2048x32 character-buffer on-chip SRAM among three requesters: two Avalon-MM masters (m0 = processor bridge, m1 = DMA) and an internal fill engine for screen clear/fill.
- Arbitration is round-robin with single-cycle issue and Avalon pipelined read semantics.
- The RAM's fixed 1-cycle read latency is returned to the correct master through readdatavalid.
- Sits between the interconnect and the SRAM's s1 port; the SRAM's clken is tied high at the top level.

Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assertion, active-low
- m0_address / m1_address  in  ADDR_W  word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- fill_start  in  1  1-cycle pulse, start fill
- fill_base  in  ADDR_W  first word to fill
- fill_count  in  ADDR_W+1  words to fill, 0..2048
- fill_data  in  DATA_W  fill word
- fill_abort  in  1  stop fill
- fill_busy  out  1  fill in progress
- fill_done  out  1  1-cycle pulse on completion
- ram_address  out  ADDR_W  to SRAM address
- ram_chipselect  out  1  to SRAM chipselect
- ram_write  out  1  to SRAM write
- ram_byteenable  out  BE_W  to SRAM byteenable
- ram_writedata  out  DATA_W  to SRAM writedata
- ram_readdata  in  DATA_W  from SRAM readdata

Behaviour:
- Reset (reset_n low, async):
  - waitrequests = 1; readdatavalids = 0; fill_busy = 0; fill_done = 0; ram_chipselect = 0; ram_write = 0.
  - RR pointer = fill, so m0 has highest priority first; fill FSM = IDLE; read tag cleared.
- Requests:
  - mX requests when read|write.
  - read&write together: treated as a write.
  - Fill requests whenever the FSM is in FILL.
- Grant:
  - Combinational, one grant per cycle.
  - Search order starts at the requester after the last granted one (m0 -> m1 -> fill -> m0).
  - Pointer updates only on a grant.
- Issue:
  - Granted master sees waitrequest = 0 in the same cycle; its address, byteenable and writedata drive the ram_* ports; ram_chipselect = 1.
  - Every non-granted master sees waitrequest = 1, including idle ones.
  - No grant: ram_chipselect = 0, ram_write = 0.
- Read return:
  - A granted read registers a valid flag and owner tag.
  - Next cycle: owner's readdatavalid = 1 and its readdata = ram_readdata.
  - readdata is don't-care when readdatavalid = 0.
  - Back-to-back reads, from the same or alternating masters, sustain one per cycle.
  - Write issue does not disturb a pending return.
- Fill FSM:
  - IDLE:
    - fill_start with count > 0: latch base, count and data; go to FILL; fill_busy = 1.
    - fill_start with count = 0: pulse fill_done next cycle; no writes.
  - FILL:
    - Each granted cycle writes fill_data to the current address with byteenable all-ones.
    - Address increments mod 2048 (0x7FF wraps to 0x000); remaining count decrements.
    - Last write granted: go to DONE.
  - DONE: fill_done = 1 for one cycle, fill_busy = 0, return to IDLE.
  - fill_start while busy: ignored.
  - fill_abort in FILL: go to IDLE next cycle with no done pulse. If the fill holds the grant in the abort cycle, that write still completes.
- Throughput: with all three requesting continuously, each gets exactly 1 of 3 cycles.

Decomposition:
- Shared package: ADDR_W, DATA_W, BE_W constants; requester index enum {REQ_M0, REQ_M1, REQ_FILL}; fill state enum {IDLE, FILL, DONE}.
- One sub-module: char_buf_fill_engine (FSM, address/count counters, request output, grant input). Arbiter and read-return logic stay in the top.

Test Plan:
- Reset, then m0 reads 0x005 alone -> waitrequest 0 same cycle; readdatavalid next cycle with RAM contents at 0x005; m1_readdatavalid stays 0.
- m0 and m1 hold reads of 0x010 and 0x020 for 4 cycles -> grants alternate m0,m1,m0,m1; each valid returns to its owner with the correct data one cycle later.
- fill_start with base 0x7FE, count 4, data 0x20202020, no other traffic -> writes at 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; fill_done pulses once; fill_busy high exactly 4 cycles.
- Fill (count 6) concurrent with continuous m0 writes -> grants interleave m0/fill 1:1; fill finishes after 6 fill grants; m0 data lands intact.
- fill_abort after 2 fill writes -> no further fill writes; no fill_done; fill_busy low next cycle.
- fill_count = 0 -> no RAM write; fill_done pulse. Assert reset_n low mid-fill -> fill_busy/readdatavalid drop immediately; no writes after release.
